irq_flag_unit: RTL and testbench
================================

IRQ_FLAG_UNIT -- requirements
Module: irq_flag_unit

Interface
REQ-001 Parameter NUM_INT SHALL be: default 16; number of interrupt lines.
REQ-002 Port clk SHALL be: input, 1 bit; single clock, all state on rising edge.
REQ-003 Port rst SHALL be: input, 1 bit; asynchronous, active-high reset.
REQ-004 Port irq_in SHALL be: input, NUM_INT bits; peripheral request lines, rising-edge triggered.
REQ-005 Port ier_in SHALL be: input, NUM_INT+1 bits; bits [NUM_INT-1:0] per-line enable, bit NUM_INT global enable.
REQ-006 Port sw_set SHALL be: input, NUM_INT bits; one-cycle software set of flag bits.
REQ-007 Port sw_clr SHALL be: input, NUM_INT bits; one-cycle software clear of flag bits.
REQ-008 Port ack SHALL be: input, 1 bit; CPU accepts the current request and enters the handler.
REQ-009 Port end_routine SHALL be: input, 1 bit; CPU returns from the handler.
REQ-010 Port ifr_out SHALL be: output, NUM_INT bits; registered flag register, feeds the controller's IFR.
REQ-011 Port irq_req SHALL be: output, 1 bit; registered request to the CPU.
REQ-012 Port irq_id SHALL be: output, 4 bits; index of the requested line, valid while irq_req=1.
REQ-013 Port in_service SHALL be: output, 1 bit; high while a handler runs.

Function
REQ-014 Edge detect SHALL use a registered copy of irq_in: bit i rises when irq_in[i]=1 now and 0 in the previous cycle.
REQ-015 A rising edge or sw_set[i] SHALL set ifr_out[i] at the same clock edge; ier_in SHALL NOT gate flag setting.
REQ-016 sw_clr[i] SHALL clear ifr_out[i]; a set and a clear on the same bit in the same cycle SHALL leave the bit set.
REQ-017 pending SHALL be ifr_out & ier_in[NUM_INT-1:0], qualified by ier_in[NUM_INT]; the lowest set index SHALL have highest priority.
REQ-018 The FSM SHALL have exactly three states: IDLE, REQUEST, SERVICE.
REQ-019 IDLE -> REQUEST SHALL occur when qualified pending is nonzero; irq_id SHALL latch the winning index on that edge.
REQ-020 In REQUEST, irq_req SHALL be 1 and irq_id SHALL stay stable, even if a higher-priority line becomes pending.
REQ-021 In REQUEST, ack=1 SHALL clear ifr_out[irq_id] and move the FSM to SERVICE on the same edge; a new edge on that line in the same cycle SHALL leave the bit set.
REQ-022 In REQUEST without ack, if the latched line is no longer qualified pending, the FSM SHALL withdraw to IDLE (irq_req=0 next cycle).
REQ-023 In SERVICE, in_service SHALL be 1 and irq_req SHALL be 0 (no nesting); flags SHALL still accumulate.
REQ-024 In SERVICE, end_routine=1 SHALL move the FSM to IDLE; re-arbitration SHALL start in the following cycle.
REQ-025 ack outside REQUEST and end_routine outside SERVICE SHALL be ignored.
REQ-026 Latency: an edge sampled at clock N SHALL give ifr_out set after N and irq_req=1 after N+1 if enabled and idle.
REQ-027 irq_req, irq_id and in_service SHALL be driven from state registers only, with no combinational path from inputs.

Reset
REQ-028 rst=1 SHALL asynchronously force IDLE, ifr_out=0, irq_req=0, irq_id=0, in_service=0, and edge history=0.
REQ-029 A reset mid-REQUEST or mid-SERVICE SHALL abandon the handler; a line held high through reset release SHALL NOT produce an edge.

Configuration
REQ-030 Macro IRQ_FLAG_SYNC_EN defined: irq_in SHALL pass through a two-flop synchronizer (reset 0) before edge detect, adding 2 cycles to REQ-026 latency.
REQ-031 Macro IRQ_FLAG_SYNC_EN undefined: irq_in SHALL feed edge detect directly, and latency SHALL be exactly as in REQ-026.

Verification
REQ-032 ier_in=0x1_0004, irq_in[2] 0->1 at clock 5 -> ifr_out=0x0004 after clock 5; irq_req=1 with irq_id=2 after clock 6; ack at clock 8 -> ifr_out=0x0000 and in_service=1.
REQ-033 ier_in=0x1_FFFF, sw_set=0x0030 -> irq_id=4; after ack and then end_routine, the next request shows irq_id=5.
REQ-034 In REQUEST for line 3, sw_clr=0x0008 without ack -> irq_req=0 next cycle, state IDLE, ifr_out[3]=0.
REQ-035 ack in the same cycle as a new rising edge on irq_id's line -> FSM in SERVICE and ifr_out bit still 1; after end_routine the line is re-requested.
REQ-036 ier_in[16]=0 with ifr_out=0x0001 -> irq_req stays 0; setting ier_in[16]=1 -> irq_req=1 one cycle later; rst pulsed in SERVICE -> all outputs 0 immediately.

Source files
------------

// File: rtl/irq_flag_unit.sv
// Interrupt flag register with edge capture, global/per-line enable, priority arbitration and a
// three-state request/service handshake. Define IRQ_FLAG_SYNC_EN to add a two-flop input synchronizer.
module irq_flag_unit #(
    parameter int unsigned NUM_INT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_INT-1:0] irq_in,
    input  logic [NUM_INT:0]   ier_in,
    input  logic [NUM_INT-1:0] sw_set,
    input  logic [NUM_INT-1:0] sw_clr,
    input  logic               ack,
    input  logic               end_routine,
    output logic [NUM_INT-1:0] ifr_out,
    output logic               irq_req,
    output logic [3:0]         irq_id,
    output logic               in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         id_q, id_d;
    logic [NUM_INT-1:0] ifr_q, ifr_d;
    logic [NUM_INT-1:0] irq_s;
    logic [NUM_INT-1:0] irq_prev;
    logic [NUM_INT-1:0] rise;
    logic [NUM_INT-1:0] qual, qual_next;
    logic [NUM_INT-1:0] id_mask;
    logic [NUM_INT-1:0] clr_mask;
    logic [3:0]         win_idx;
    logic               win_found;
    logic               ack_clr;
    logic               latched_pending;

`ifdef IRQ_FLAG_SYNC_EN
    localparam int unsigned ARM_LEN = 3;
    logic [NUM_INT-1:0] sync1, sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end

    assign irq_s = sync2;
`else
    localparam int unsigned ARM_LEN = 1;
    assign irq_s = irq_in;
`endif

    // Edges stay masked until the history has seen the first post-reset sample of the line,
    // so a line held high through reset release is not mistaken for a rising edge.
    logic [ARM_LEN-1:0] arm_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev <= '0;
            arm_sr   <= '0;
        end else begin
            irq_prev <= irq_s;
            arm_sr   <= {arm_sr, 1'b1};
        end
    end

    assign rise = arm_sr[ARM_LEN-1] ? (irq_s & ~irq_prev) : '0;

    always_comb begin
        id_mask = '0;
        for (int unsigned i = 0; i < NUM_INT; i++) begin
            id_mask[i] = (id_q == 4'(i));
        end
    end

    assign ack_clr  = (state_q == REQUEST) && ack;
    assign clr_mask = sw_clr | (ack_clr ? id_mask : '0);
    assign ifr_d    = (ifr_q & ~clr_mask) | rise | sw_set;

    assign qual      = ier_in[NUM_INT] ? (ifr_q & ier_in[NUM_INT-1:0]) : '0;
    assign qual_next = ier_in[NUM_INT] ? (ifr_d & ier_in[NUM_INT-1:0]) : '0;
    // Withdrawal looks at the post-update flags so a clear drops the request on the next edge.
    assign latched_pending = |(qual_next & id_mask);

    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < NUM_INT; i++) begin
            if (qual[i] && !win_found) begin
                win_idx   = 4'(i);
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            ifr_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ifr_q   <= ifr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = REQUEST;
                    id_d    = win_idx;
                end
            end
            REQUEST: begin
                if (ack) begin
                    state_d = SERVICE;
                end else if (!latched_pending) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (end_routine) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        irq_req    = (state_q == REQUEST);
        in_service = (state_q == SERVICE);
        irq_id     = id_q;
        ifr_out    = ifr_q;
    end

endmodule

// File: tb/tb_irq_flag_unit.sv
// Directed self-checking bench for irq_flag_unit (default build, no input synchronizer).
module tb_irq_flag_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] irq_in;
    logic [16:0] ier_in;
    logic [15:0] sw_set;
    logic [15:0] sw_clr;
    logic        ack;
    logic        end_routine;
    logic [15:0] ifr_out;
    logic        irq_req;
    logic [3:0]  irq_id;
    logic        in_service;

    int checks = 0;
    int errors = 0;

    irq_flag_unit #(.NUM_INT(16)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .ier_in(ier_in),
        .sw_set(sw_set), .sw_clr(sw_clr), .ack(ack), .end_routine(end_routine),
        .ifr_out(ifr_out), .irq_req(irq_req), .irq_id(irq_id), .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_in = '0; ier_in = '0; sw_set = '0; sw_clr = '0;
        ack = 1'b0; end_routine = 1'b0;
        #2;
        checks++; if (ifr_out !== 16'h0) begin errors++; $display("FAIL reset_ifr got %h exp %h", ifr_out, 16'h0); end
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", irq_req); end
        checks++; if (irq_id !== 4'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", irq_id); end
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL reset_svc got %b exp 0", in_service); end
        step(); step();
        rst = 1'b0;
        step(); step();
    endtask

    task automatic test_basic_edge();
        ier_in = 17'h1_0004;
        irq_in = 16'h0004;
        step();
        checks++; if (ifr_out !== 16'h0004) begin errors++; $display("FAIL edge_ifr got %h exp %h", ifr_out, 16'h0004); end
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL edge_req_early got %b exp 0", irq_req); end
        step();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL edge_req got %b exp 1", irq_req); end
        checks++; if (irq_id !== 4'd2) begin errors++; $display("FAIL edge_id got %0d exp 2", irq_id); end
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (ifr_out !== 16'h0000) begin errors++; $display("FAIL ack_ifr got %h exp %h", ifr_out, 16'h0); end
        checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL ack_svc got %b exp 1", in_service); end
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL svc_req got %b exp 0", irq_req); end
        end_routine = 1'b1;
        step();
        end_routine = 1'b0;
        step(); step();
        checks++; if (ifr_out !== 16'h0000) begin errors++; $display("FAIL held_level_ifr got %h exp %h", ifr_out, 16'h0); end
        checks++; if (in_service !== 1'b0 || irq_req !== 1'b0) begin errors++; $display("FAIL end_idle got svc=%b req=%b exp 0/0", in_service, irq_req); end
        irq_in = '0;
        step();
    endtask

    task automatic test_priority();
        ier_in = 17'h1_FFFF;
        sw_set = 16'h0030;
        step();
        sw_set = '0;
        checks++; if (ifr_out !== 16'h0030) begin errors++; $display("FAIL prio_ifr got %h exp %h", ifr_out, 16'h0030); end
        step();
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd4) begin errors++; $display("FAIL prio_first got req=%b id=%0d exp 1/4", irq_req, irq_id); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (ifr_out !== 16'h0020) begin errors++; $display("FAIL prio_ack_ifr got %h exp %h", ifr_out, 16'h0020); end
        end_routine = 1'b1;
        step();
        end_routine = 1'b0;
        checks++; if (irq_req !== 1'b0 || in_service !== 1'b0) begin errors++; $display("FAIL prio_idle got req=%b svc=%b exp 0/0", irq_req, in_service); end
        step();
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd5) begin errors++; $display("FAIL prio_second got req=%b id=%0d exp 1/5", irq_req, irq_id); end
        ack = 1'b1; step(); ack = 1'b0;
        end_routine = 1'b1; step(); end_routine = 1'b0;
        checks++; if (ifr_out !== 16'h0000) begin errors++; $display("FAIL prio_drain got %h exp %h", ifr_out, 16'h0); end
    endtask

    task automatic test_id_stable();
        sw_set = 16'h0010;
        step();
        sw_set = 16'h0001;
        step();
        sw_set = '0;
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd4) begin errors++; $display("FAIL stable_id got req=%b id=%0d exp 1/4", irq_req, irq_id); end
        checks++; if (ifr_out !== 16'h0011) begin errors++; $display("FAIL stable_ifr got %h exp %h", ifr_out, 16'h0011); end
        step();
        checks++; if (irq_id !== 4'd4) begin errors++; $display("FAIL stable_hold got %0d exp 4", irq_id); end
        ack = 1'b1; step(); ack = 1'b0;
        checks++; if (ifr_out !== 16'h0001) begin errors++; $display("FAIL stable_ack_ifr got %h exp %h", ifr_out, 16'h0001); end
        end_routine = 1'b1; step(); end_routine = 1'b0;
        step();
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd0) begin errors++; $display("FAIL stable_next got req=%b id=%0d exp 1/0", irq_req, irq_id); end
        ack = 1'b1; step(); ack = 1'b0;
        end_routine = 1'b1; step(); end_routine = 1'b0;
    endtask

    task automatic test_withdraw();
        sw_set = 16'h0008;
        step();
        sw_set = '0;
        step();
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd3) begin errors++; $display("FAIL wd_req got req=%b id=%0d exp 1/3", irq_req, irq_id); end
        sw_clr = 16'h0008;
        step();
        sw_clr = '0;
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL wd_drop got %b exp 0", irq_req); end
        checks++; if (ifr_out !== 16'h0000) begin errors++; $display("FAIL wd_ifr got %h exp %h", ifr_out, 16'h0); end
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL wd_svc got %b exp 0", in_service); end
        step();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL wd_stay got %b exp 0", irq_req); end
    endtask

    task automatic test_ack_edge();
        irq_in = 16'h0080;
        step();
        irq_in = '0;
        checks++; if (ifr_out !== 16'h0080) begin errors++; $display("FAIL ae_ifr got %h exp %h", ifr_out, 16'h0080); end
        step();
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd7) begin errors++; $display("FAIL ae_req got req=%b id=%0d exp 1/7", irq_req, irq_id); end
        ack = 1'b1;
        irq_in = 16'h0080;
        step();
        ack = 1'b0;
        checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL ae_svc got %b exp 1", in_service); end
        checks++; if (ifr_out !== 16'h0080) begin errors++; $display("FAIL ae_keep got %h exp %h", ifr_out, 16'h0080); end
        end_routine = 1'b1;
        step();
        end_routine = 1'b0;
        step();
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd7) begin errors++; $display("FAIL ae_rereq got req=%b id=%0d exp 1/7", irq_req, irq_id); end
        ack = 1'b1; step(); ack = 1'b0;
        checks++; if (ifr_out !== 16'h0000) begin errors++; $display("FAIL ae_clear got %h exp %h", ifr_out, 16'h0); end
        end_routine = 1'b1; step(); end_routine = 1'b0;
        irq_in = '0;
        step();
    endtask

    task automatic test_gating_and_reset();
        ier_in = 17'h0_FFFF;
        sw_set = 16'h0002; sw_clr = 16'h0002;
        step();
        sw_set = '0; sw_clr = '0;
        checks++; if (ifr_out !== 16'h0002) begin errors++; $display("FAIL set_wins got %h exp %h", ifr_out, 16'h0002); end
        sw_clr = 16'h0002; sw_set = 16'h0001;
        step();
        sw_clr = '0; sw_set = '0;
        checks++; if (ifr_out !== 16'h0001) begin errors++; $display("FAIL gate_ifr got %h exp %h", ifr_out, 16'h0001); end
        ack = 1'b1; end_routine = 1'b1;
        step();
        ack = 1'b0; end_routine = 1'b0;
        step();
        checks++; if (ifr_out !== 16'h0001 || in_service !== 1'b0) begin errors++; $display("FAIL idle_ignore got ifr=%h svc=%b exp 0001/0", ifr_out, in_service); end
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL gate_off got %b exp 0", irq_req); end
        ier_in = 17'h1_FFFF;
        step();
        checks++; if (irq_req !== 1'b1 || irq_id !== 4'd0) begin errors++; $display("FAIL gate_on got req=%b id=%0d exp 1/0", irq_req, irq_id); end
        ack = 1'b1; step(); ack = 1'b0;
        sw_set = 16'h0040; step(); sw_set = '0;
        checks++; if (in_service !== 1'b1 || ifr_out !== 16'h0040) begin errors++; $display("FAIL svc_accum got svc=%b ifr=%h exp 1/0040", in_service, ifr_out); end
        irq_in = 16'h0100;
        #2 rst = 1'b1;
        #1;
        checks++; if (ifr_out !== 16'h0 || irq_req !== 1'b0 || irq_id !== 4'd0 || in_service !== 1'b0)
            begin errors++; $display("FAIL async_rst got ifr=%h req=%b id=%0d svc=%b exp 0/0/0/0", ifr_out, irq_req, irq_id, in_service); end
        step(); step();
        rst = 1'b0;
        step(); step(); step();
        checks++; if (ifr_out !== 16'h0000 || irq_req !== 1'b0) begin errors++; $display("FAIL held_through_rst got ifr=%h req=%b exp 0000/0", ifr_out, irq_req); end
        irq_in = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic_edge();
        test_priority();
        test_id_stable();
        test_withdraw();
        test_ack_edge();
        test_gating_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
